// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - walks neurons x input chunks of one FC layer through a single PU.
// Optional busy-cycle counter port perf_cycles is built when LAYER_SEQ_PERF_EN is defined.
module layer_sequencer #(
  parameter int N_NEURONS = 8,
  parameter int N_CHUNKS  = 4,
  parameter int XAW       = 2,
  parameter int WAW       = 5,
  parameter int NAW       = 3
) (
  input  logic           clk,
  input  logic           rst,
`ifdef LAYER_SEQ_PERF_EN
  output logic [15:0]    perf_cycles,
`endif
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [XAW-1:0] x_addr,
  output logic [WAW-1:0] w_addr,
  output logic [NAW-1:0] b_addr,
  output logic           isfirst,
  input  logic [7:0]     pu_out,
  output logic           wr_en,
  output logic [NAW-1:0] wr_addr,
  output logic [7:0]     wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [XAW-1:0] LAST_CHUNK  = XAW'(N_CHUNKS - 1);
  localparam logic [NAW-1:0] LAST_NEURON = NAW'(N_NEURONS - 1);

  state_t         state_q, state_d;
  logic [XAW-1:0] x_q, x_d;
  logic [WAW-1:0] w_q, w_d;
  logic [NAW-1:0] b_q, b_d;
  logic           stage_valid_q, stage_valid_d;
  logic           stage_first_q, stage_first_d;
  logic           stage_last_q, stage_last_d;
  logic [NAW-1:0] stage_neuron_q, stage_neuron_d;
  logic           wr_en_q, wr_en_d;
  logic [NAW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic           issue_last;
  logic           start_ok;

  assign start_ok   = (state_q == S_IDLE) && start;
  assign issue_last = (state_q == S_ISSUE) && (x_q == LAST_CHUNK) && (b_q == LAST_NEURON);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (issue_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    isfirst = stage_valid_q & stage_first_q;
  end

  // Address registers double as the chunk/neuron counters and hold after the final issue.
  always_comb begin
    x_d            = x_q;
    w_d            = w_q;
    b_d            = b_q;
    stage_valid_d  = 1'b0;
    stage_first_d  = stage_first_q;
    stage_last_d   = stage_last_q;
    stage_neuron_d = stage_neuron_q;
    wr_en_d        = stage_valid_q & stage_last_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    if (stage_valid_q && stage_last_q) begin
      wr_addr_d = stage_neuron_q;
      wr_data_d = pu_out;
    end
    if (start_ok) begin
      x_d = '0;
      w_d = '0;
      b_d = '0;
    end
    if (state_q == S_ISSUE) begin
      stage_valid_d  = 1'b1;
      stage_first_d  = (x_q == '0);
      stage_last_d   = (x_q == LAST_CHUNK);
      stage_neuron_d = b_q;
      if (!issue_last) begin
        w_d = w_q + 1'b1;
        if (x_q == LAST_CHUNK) begin
          x_d = '0;
          b_d = b_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      w_q            <= '0;
      b_q            <= '0;
      stage_valid_q  <= 1'b0;
      stage_first_q  <= 1'b0;
      stage_last_q   <= 1'b0;
      stage_neuron_q <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      x_q            <= x_d;
      w_q            <= w_d;
      b_q            <= b_d;
      stage_valid_q  <= stage_valid_d;
      stage_first_q  <= stage_first_d;
      stage_last_q   <= stage_last_d;
      stage_neuron_q <= stage_neuron_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign x_addr  = x_q;
  assign w_addr  = w_q;
  assign b_addr  = b_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef LAYER_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_ok) begin
      perf_d = '0;
    end else if (busy && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences one fully-connected layer through a single PU. It walks every neuron and every 8-lane input chunk, issuing addresses to the input, weight and bias memories. It drives PU `isfirst` so each neuron's accumulation starts from its bias, and writes the PU's activated 8-bit result to the output buffer once the neuron's last chunk has been summed. It sits between the layer-level top and one PU plus its three synchronous-read memories.

## Interface
Parameters:
- N_NEURONS, 8, neurons in the layer (≥1)
- N_CHUNKS, 4, 8-lane input chunks per neuron (≥1)
- XAW, 2, input-memory address width (2^XAW ≥ N_CHUNKS)
- WAW, 5, weight-memory address width (2^WAW ≥ N_NEURONS*N_CHUNKS)
- NAW, 3, bias/output address width (2^NAW ≥ N_NEURONS)

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  rising-edge clock shared with PU and memories
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to run the layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final output write
- x_addr  out  XAW  input-memory address (chunk index)
- w_addr  out  WAW  weight-memory address = neuron*N_CHUNKS + chunk
- b_addr  out  NAW  bias-memory address = neuron
- isfirst  out  1  to PU; high while chunk 0 data of a neuron is at the PU
- pu_out  in  8  PU activated output, combinational from current data
- wr_en  out  1  output-buffer write strobe
- wr_addr  out  NAW  output-buffer address (neuron index)
- wr_data  out  8  registered copy of pu_out at write

## Operation
- State machine with four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 loads neuron=0, chunk=0 and moves to ISSUE.
- ISSUE: one address set per cycle.
  - Chunk increments each cycle.
  - At chunk=N_CHUNKS-1, chunk wraps to 0 and neuron increments.
  - After issuing neuron N_NEURONS-1, chunk N_CHUNKS-1, the state moves to DRAIN.
- DRAIN: one cycle that lets the last read return. Then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Memories have a 1-cycle read latency. A one-stage valid pipeline carries `first`, `last` and `neuron` alongside each issued address, so `isfirst` and the write align with returning data.
- `isfirst` = stage-valid & first. The PU selects bias instead of its acc register that cycle.
- On stage-valid & last:
  - `wr_en`=1 and `wr_addr`=stage neuron are registered.
  - `wr_data`=pu_out is captured, so the write appears one cycle after the data sits at the PU.
- N_CHUNKS=1: first and last coincide. `isfirst` and write capture happen in the same data cycle.
- Addresses hold their last value outside ISSUE. `isfirst`=0 whenever the stage is invalid.
- `start` during busy is ignored, with no queuing.
- Reset mid-operation:
  - Next state is IDLE; counters and pipeline valid are cleared.
  - No further `wr_en`; `done` is not pulsed.

## Timing
- Reset values: busy=0, done=0, isfirst=0, wr_en=0, x_addr=0, w_addr=0, b_addr=0, wr_addr=0, wr_data=0.
- Cycle 0: start=1 sampled.
- Cycles 1 … T, where T = N_NEURONS*N_CHUNKS: ISSUE, one address per cycle. busy=1 from cycle 1.
- Issue at cycle t produces data at the PU in cycle t+1.
- isfirst is high in cycles 2, 2+N_CHUNKS, ….
- wr_en for neuron n is high in cycle (n+1)*N_CHUNKS+2.
- Cycle T+1: DRAIN. Cycle T+2: DONE, done=1, last wr_en also in this cycle.
- busy drops at cycle T+3. A new start is accepted in cycle T+3 at the earliest.
- Total latency start→done = T+2 cycles.

## Configuration
- `LAYER_SEQ_PERF_EN` defined:
  - Adds output port perf_cycles[15:0], which counts cycles with busy=1.
  - The count clears on accepted start and on rst, and saturates at 16'hFFFF.
  - The count holds its value after done.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- N_NEURONS=2, N_CHUNKS=4, single start at cycle 0:
  - w_addr follows 0..7 in cycles 1..8.
  - isfirst is high in cycles 2 and 6 only.
  - wr_en is high in cycles 6 and 10 with wr_addr 0, 1.
  - done is high in cycle 10.
- PU-model data check with x=all 1, w=all 2, bias=3:
  - Per 8-lane chunk, the dot product is 16 in the PU's 8-bit value format.
  - wr_data for each neuron equals the PU result of bias + 4 chunks.
  - Accumulation never carries across neurons.
- N_CHUNKS=1, N_NEURONS=3: isfirst is continuously high cycles 2–4; wr_en is high cycles 3–5 with wr_addr 0, 1, 2.
- start pulsed again at cycle 4 of a 10-cycle run: ignored, exactly N_NEURONS writes, one done.
- rst asserted at cycle 5:
  - busy=0 and wr_en=0 from cycle 6, and no done pulse.
  - A subsequent start runs cleanly from neuron 0.
- With LAYER_SEQ_PERF_EN, N_NEURONS=2, N_CHUNKS=4: perf_cycles=10 after done. Built without the macro, the bench compiles with no perf port.
